// File: rtl/lsu_pkg.sv
// Purpose: shared types and decode helpers for the byte-serial load/store unit.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
// Contents: funct3 constants, FSM state enum, size decode, legality and alignment checks.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } lsu_state_e;

  // n: number of bytes (1, 2 or 4); sgn: sign-extend on load
  typedef struct packed {
    logic [2:0] n;
    logic       sgn;
  } lsu_size_t;

  function automatic lsu_size_t lsu_size_decode(input logic [2:0] f3);
    lsu_size_t s;
    s.n   = 3'd1;
    s.sgn = 1'b1;
    case (f3)
      F3_H:  s.n = 3'd2;
      F3_W:  s.n = 3'd4;
      F3_BU: s.sgn = 1'b0;
      F3_HU: begin
        s.n   = 3'd2;
        s.sgn = 1'b0;
      end
      default: s.n = 3'd1;
    endcase
    return s;
  endfunction

  // Unsigned variants only make sense for loads.
  function automatic logic lsu_legal(input logic [2:0] f3, input logic we);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic lsu_misaligned(input logic [2:0] n, input logic [1:0] a);
    return ((n == 3'd2) && a[0]) || ((n == 3'd4) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Purpose: sign/zero extension of the assembled little-endian load bytes.
// Latency: combinational.
// Backpressure: none.
// Ports: n (1/2/4 bytes), sgn (sign-extend), bytes_in (assembled bytes, low-aligned), data_out (XLEN).
module lsu_extend #(
  parameter int XLEN = 32
) (
  input  logic [2:0]      n,
  input  logic            sgn,
  input  logic [XLEN-1:0] bytes_in,
  output logic [XLEN-1:0] data_out
);

  always_comb begin
    data_out = bytes_in;
    case (n)
      3'd1:    data_out = {{(XLEN-8){sgn & bytes_in[7]}}, bytes_in[7:0]};
      3'd2:    data_out = {{(XLEN-16){sgn & bytes_in[15]}}, bytes_in[15:0]};
      default: data_out = bytes_in;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Purpose: turns one RV32 load/store into byte accesses on a byte-wide memory port.
// Latency: illegal 1 cycle; store N+1; load N+2 (N = access size in bytes).
// Backpressure: req_ready only in IDLE; response is a one-cycle pulse with no backpressure.
// Ports: clk/rst (sync, active-high); req_* request in; resp_* completion out;
//        mem_wd/mem_rd strobes, mem_addr_in (write addr), mem_addr_out (read addr),
//        mem_data_out (write byte), mem_data_in (read byte, 1 cycle after mem_rd).
// Config: define LSU_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int XLEN       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [XLEN-1:0]       req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [XLEN-1:0]       resp_rdata,
  output logic                  mem_wd,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr_in,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic [7:0]            mem_data_out,
  input  logic [7:0]            mem_data_in
);

  lsu_state_e            state_q, state_d;
  logic                  we_q;
  logic [2:0]            n_q;
  logic                  sgn_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [XLEN-1:0]       wdata_q;
  logic [1:0]            k_q;
  logic [XLEN-1:0]       bytes_q;
  logic                  err_q;
  logic [XLEN-1:0]       rdata_q;

  lsu_size_t             req_size;
  logic                  req_legal;
  logic                  accept;
  logic [1:0]            k_last;
  logic                  in_access;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [XLEN-1:0]       cap_bytes;
  logic [XLEN-1:0]       ext_data;
  logic                  unused_addr_hi;

  // Request addresses are truncated to the memory width.
  assign unused_addr_hi = ^req_addr[XLEN-1:ADDR_WIDTH];

  always_comb begin
    req_size  = lsu_size_decode(req_funct3);
    req_legal = lsu_legal(req_funct3, req_we);
`ifdef LSU_MISALIGN_TRAP_EN
    if (lsu_misaligned(req_size.n, req_addr[1:0])) begin
      req_legal = 1'b0;
    end
`endif
  end

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign k_last    = 2'(n_q - 3'd1);
  assign in_access = (state_q == ACCESS);
  assign cur_addr  = addr_q + ADDR_WIDTH'(k_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = req_legal ? ACCESS : RESP;
      ACCESS:  if (k_q == k_last) state_d = we_q ? RESP : CAPTURE;
      CAPTURE: state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The last byte arrives during CAPTURE; merge it straight into the extender input.
  always_comb begin
    cap_bytes = bytes_q;
    cap_bytes[{k_last, 3'b000} +: 8] = mem_data_in;
  end

  lsu_extend #(.XLEN(XLEN)) u_extend (
    .n        (n_q),
    .sgn      (sgn_q),
    .bytes_in (cap_bytes),
    .data_out (ext_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      n_q     <= 3'd1;
      sgn_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      k_q     <= 2'd0;
      bytes_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            we_q    <= req_we;
            n_q     <= req_size.n;
            sgn_q   <= req_size.sgn;
            addr_q  <= req_addr[ADDR_WIDTH-1:0];
            wdata_q <= req_wdata;
            k_q     <= 2'd0;
            bytes_q <= '0;
            err_q   <= ~req_legal;
            rdata_q <= '0;
          end
        end
        ACCESS: begin
          k_q <= k_q + 2'd1;
          // Read data lags the strobe by one cycle: byte k-1 is on the bus now.
          if (!we_q && (k_q != 2'd0)) begin
            bytes_q[{k_q - 2'd1, 3'b000} +: 8] <= mem_data_in;
          end
        end
        CAPTURE: rdata_q <= ext_data;
        default: ;
      endcase
    end
  end

  assign mem_wd       = in_access && we_q;
  assign mem_rd       = in_access && !we_q;
  assign mem_addr_in  = in_access ? cur_addr : '0;
  assign mem_addr_out = in_access ? cur_addr : '0;
  assign mem_data_out = (in_access && we_q) ? wdata_q[{k_q, 3'b000} +: 8] : 8'h00;

  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = resp_valid ? rdata_q : '0;

endmodule
